// File: rtl/arf124b192e1r1w0cbbehcaa4acw_init_wr_ctl.sv
// ----------------------------------------------------------------------------
// arf124b192e1r1w0cbbehcaa4acw_init_wr_ctl
//
// Write-side front end for the 192 x 124 1R1W register file array.
//   - Re-synchronizes the deassertion of rstb (two-flop reset synchronizer).
//   - After reset, or on init_req while DONE, sweeps every entry with INIT_VAL.
//   - Once initialized, registers and forwards functional writes and reads.
//
// Ports
//   clk            : single clock
//   rstb           : async-assert, active-low reset (deassertion re-synced)
//   init_req       : one-cycle re-sweep request, honoured only in DONE
//   fn_wr_en/adr/data : functional write request
//   fn_rd_en/adr      : functional read request
//   arr_wr_en/adr/data: registered array write port
//   arr_wr_clk_en     : write clock-gate enable (same as arr_wr_en)
//   arr_rd_en/adr     : registered array read port
//   init_busy      : sweep in progress
//   init_done      : array initialized, functional traffic accepted
//   wr_drop        : one-cycle pulse, a functional request was discarded
// ----------------------------------------------------------------------------
module arf124b192e1r1w0cbbehcaa4acw_init_wr_ctl #(
    parameter int            DEPTH    = 192,
    parameter int            AW       = 8,
    parameter int            DW       = 124,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          init_req,
    input  logic          fn_wr_en,
    input  logic [AW-1:0] fn_wr_adr,
    input  logic [DW-1:0] fn_wr_data,
    input  logic          fn_rd_en,
    input  logic [AW-1:0] fn_rd_adr,
    output logic          arr_wr_en,
    output logic          arr_wr_clk_en,
    output logic [AW-1:0] arr_wr_adr,
    output logic [DW-1:0] arr_wr_data,
    output logic          arr_rd_en,
    output logic [AW-1:0] arr_rd_adr,
    output logic          init_busy,
    output logic          init_done,
    output logic          wr_drop
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        INIT     = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Reset synchronizer: clears with rstb, sets on the 2nd edge after
    // release. Stands in for the doublesync_rstb cell.
    // ------------------------------------------------------------------
    logic [1:0] sync_pipe;
    logic       rs_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sync_pipe <= 2'b00;
        else       sync_pipe <= {sync_pipe[0], 1'b1};
    end

    assign rs_q = sync_pipe[1];

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;

    logic          wr_en_n, rd_en_n, busy_n, done_n, drop_n;
    logic [AW-1:0] wr_adr_n, rd_adr_n;
    logic [DW-1:0] wr_data_n;

    logic wr_ok, rd_ok, fn_any;

    assign wr_ok  = {1'b0, fn_wr_adr} < DEPTH_W;
    assign rd_ok  = {1'b0, fn_rd_adr} < DEPTH_W;
    assign fn_any = fn_wr_en | fn_rd_en;

    // cnt mirrors the address currently on arr_wr_adr during the sweep;
    // outputs are computed for the next cycle and registered, so the first
    // sweep write appears right after the edge that enters INIT.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        wr_en_n   = 1'b0;
        wr_adr_n  = '0;
        wr_data_n = '0;
        rd_en_n   = 1'b0;
        rd_adr_n  = '0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        drop_n    = 1'b0;

        case (state)
            RST_WAIT: begin
                drop_n = fn_any;
                if (rs_q) begin
                    state_n   = INIT;
                    cnt_n     = '0;
                    wr_en_n   = 1'b1;
                    wr_data_n = INIT_VAL;
                    busy_n    = 1'b1;
                end
            end

            INIT: begin
                // init_req is ignored here and not remembered.
                drop_n = fn_any;
                if (cnt == LAST) begin
                    // Counter saturates at LAST; it is reloaded on re-init.
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n     = cnt + 1'b1;
                    wr_en_n   = 1'b1;
                    wr_adr_n  = cnt + 1'b1;
                    wr_data_n = INIT_VAL;
                    busy_n    = 1'b1;
                end
            end

            DONE: begin
                if (init_req) begin
                    // Re-init wins over any same-cycle functional request.
                    state_n   = INIT;
                    cnt_n     = '0;
                    wr_en_n   = 1'b1;
                    wr_data_n = INIT_VAL;
                    busy_n    = 1'b1;
                    drop_n    = fn_any;
                end else begin
                    done_n = 1'b1;
                    if (fn_wr_en) begin
                        if (wr_ok) begin
                            wr_en_n   = 1'b1;
                            wr_adr_n  = fn_wr_adr;
                            wr_data_n = fn_wr_data;
                        end else begin
                            drop_n = 1'b1;
                        end
                    end
                    // Same-address read+write both go through; the array
                    // owns read-during-write behaviour.
                    if (fn_rd_en) begin
                        if (rd_ok) begin
                            rd_en_n  = 1'b1;
                            rd_adr_n = fn_rd_adr;
                        end else begin
                            drop_n = 1'b1;
                        end
                    end
                end
            end

            default: state_n = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= RST_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            arr_wr_en   <= 1'b0;
            arr_wr_adr  <= '0;
            arr_wr_data <= '0;
            arr_rd_en   <= 1'b0;
            arr_rd_adr  <= '0;
            init_busy   <= 1'b0;
            init_done   <= 1'b0;
            wr_drop     <= 1'b0;
        end else begin
            arr_wr_en   <= wr_en_n;
            arr_wr_adr  <= wr_adr_n;
            arr_wr_data <= wr_data_n;
            arr_rd_en   <= rd_en_n;
            arr_rd_adr  <= rd_adr_n;
            init_busy   <= busy_n;
            init_done   <= done_n;
            wr_drop     <= drop_n;
        end
    end

    assign arr_wr_clk_en = arr_wr_en;

endmodule
